// File: rtl/aes_sbox_pipe.sv
// Pipelined multi-lane AES S-box with valid/ready flow control and flush.
// Define AES_SBOX_INV_EN to compile in the per-transaction inverse (InvSubBytes) mode.
module aes_sbox_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic                 g_clk,
  input  logic                 g_rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_dec,
  input  logic [3:0]           in_tag,
  input  logic [8*LANES-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_tag,
  output logic [8*LANES-1:0]   out_data
);

  localparam int W = 8 * LANES;

  function automatic logic [7:0] rotl(input logic [7:0] x, input int s);
    return (x << s) | (x >> (8 - s));
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_sq(input logic [7:0] x);
    return gf_mul(x, x);
  endfunction

  // x^-1 = x^16 * (x^17)^14, where the norm x^17 lives in the GF(2^4) subfield.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x16, n, n2, n4, n8;
    x16 = gf_sq(gf_sq(gf_sq(gf_sq(x))));
    n   = gf_mul(x16, x);
    n2  = gf_sq(n);
    n4  = gf_sq(n2);
    n8  = gf_sq(n4);
    return gf_mul(x16, gf_mul(gf_mul(n8, n4), n2));
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] x);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

`ifdef AES_SBOX_INV_EN
  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
  endfunction

  // Layer ids: 0 = top (linear), 1 = middle (inversion), 2 = bottom (linear).
  function automatic logic [7:0] layers(input logic [7:0] x, input logic dec,
                                        input int first, input int last);
    logic [7:0] b;
    b = x;
    if (first <= 0 && last >= 0) b = dec ? inv_affine(b) : b;
    if (first <= 1 && last >= 1) b = gf_inv(b);
    if (first <= 2 && last >= 2) b = dec ? b : fwd_affine(b);
    return b;
  endfunction
`else
  function automatic logic [7:0] layers(input logic [7:0] x, input int first, input int last);
    logic [7:0] b;
    b = x;
    if (first <= 1 && last >= 1) b = gf_inv(b);
    if (first <= 2 && last >= 2) b = fwd_affine(b);
    return b;
  endfunction
`endif

  logic [STAGES-1:0] v_all;
  logic [STAGES-1:0] adv;
  logic [W-1:0]      data_all [STAGES];
  logic [3:0]        tag_all  [STAGES];
  logic              full_tail;
`ifdef AES_SBOX_INV_EN
  logic [STAGES-1:0] dec_all;
`else
  logic              unused_dec;
  assign unused_dec = in_dec;
`endif

  // A stage may load unless it and every later stage are occupied with the output stalled.
  always_comb begin
    adv       = '0;
    full_tail = 1'b1;
    for (int k = 0; k < STAGES; k++) begin
      full_tail = 1'b1;
      for (int j = k; j < STAGES; j++) full_tail = full_tail & v_all[j];
      adv[k] = !full_tail || out_ready;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int FIRST = (k == 0) ? 0 : k + 3 - STAGES;
    localparam int LAST  = (k == STAGES - 1) ? 2 : k + 3 - STAGES;

    logic [W-1:0] src_data, nxt_data, data_q;
    logic [3:0]   src_tag, tag_q;
    logic         src_valid, v_q;
`ifdef AES_SBOX_INV_EN
    logic         src_dec, dec_q;
`endif

    if (k == 0) begin : g_head
      assign src_data  = in_data;
      assign src_tag   = in_tag;
      assign src_valid = in_valid;
`ifdef AES_SBOX_INV_EN
      assign src_dec   = in_dec;
`endif
    end else begin : g_body
      assign src_data  = data_all[k-1];
      assign src_tag   = tag_all[k-1];
      assign src_valid = v_all[k-1];
`ifdef AES_SBOX_INV_EN
      assign src_dec   = dec_all[k-1];
`endif
    end

    always_comb begin
      nxt_data = '0;
      for (int i = 0; i < LANES; i++) begin
`ifdef AES_SBOX_INV_EN
        nxt_data[8*i +: 8] = layers(src_data[8*i +: 8], src_dec, FIRST, LAST);
`else
        nxt_data[8*i +: 8] = layers(src_data[8*i +: 8], FIRST, LAST);
`endif
      end
    end

    // Payload only loads on an advance carrying a valid, so stalled outputs never toggle.
    always_ff @(posedge g_clk or posedge g_rst) begin
      if (g_rst) begin
        v_q    <= 1'b0;
        data_q <= '0;
        tag_q  <= '0;
`ifdef AES_SBOX_INV_EN
        dec_q  <= 1'b0;
`endif
      end else begin
        if (flush)       v_q <= 1'b0;
        else if (adv[k]) v_q <= src_valid;
        if (adv[k] && src_valid) begin
          data_q <= nxt_data;
          tag_q  <= src_tag;
`ifdef AES_SBOX_INV_EN
          dec_q  <= src_dec;
`endif
        end
      end
    end

    assign v_all[k]    = v_q;
    assign data_all[k] = data_q;
    assign tag_all[k]  = tag_q;
`ifdef AES_SBOX_INV_EN
    assign dec_all[k]  = dec_q;
`endif
  end

  assign in_ready  = adv[0];
  assign out_valid = v_all[STAGES-1];
  assign out_data  = data_all[STAGES-1];
  assign out_tag   = tag_all[STAGES-1];

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Bench for aes_sbox_pipe: directed steps plus random traffic against a table-driven queue model.
// Inverse-mode steps run only when AES_SBOX_INV_EN is defined.
module tb_aes_sbox_pipe;
  localparam int LANES  = 4;
  localparam int STAGES = 3;
`ifdef AES_SBOX_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic        g_clk = 1'b0;
  logic        g_rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_dec = 1'b0;
  logic [3:0]  in_tag = '0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_tag;
  logic [31:0] out_data;

  aes_sbox_pipe #(.LANES(LANES), .STAGES(STAGES)) dut (
    .g_clk(g_clk), .g_rst(g_rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec),
    .in_tag(in_tag), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_data(out_data)
  );

  always #5 g_clk = ~g_clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
    int unsigned at_edge;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  fwd_tab [256];
  logic [7:0]  inv_tab [256];
  int          checks = 0;
  int          errors = 0;
  int unsigned edges  = 0;

  function automatic int rotl8(input int x, input int s);
    return ((x << s) | (x >> (8 - s))) & 255;
  endfunction

  // Classic generator walk: p steps through powers of 3, q through powers of 3^-1.
  task automatic build_tables();
    int p, q, x;
    p = 1;
    q = 1;
    do begin
      p = (p ^ (p << 1) ^(((p & 128) != 0) ? 27 : 0)) & 255;
      q = (q ^ (q << 1)) & 255;
      q = (q ^ (q << 2)) & 255;
      q = (q ^ (q << 4)) & 255;
      if ((q & 128) != 0) q = q ^ 9;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      fwd_tab[p] = 8'(x ^ 99);
    end while (p != 1);
    fwd_tab[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic dec);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < LANES; j++)
      r[8*j +: 8] = (INV_EN && dec) ? inv_tab[d[8*j +: 8]] : fwd_tab[d[8*j +: 8]];
    return r;
  endfunction

  task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One clock of traffic: checks handshake outputs against the occupancy model, then advances.
  task automatic apply_stimulus(input logic iv, input logic [31:0] data, input logic [3:0] tag,
                                input logic dec, input logic ordy, input logic fl,
                                output logic accepted);
    exp_t e;
    logic exp_ov;
    in_valid  = iv;
    in_data   = data;
    in_tag    = tag;
    in_dec    = dec;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_output("in_ready", {31'b0, in_ready}, {31'b0, (sb.size() < STAGES) || ordy});
    exp_ov = 1'b0;
    if (sb.size() > 0) exp_ov = (edges >= sb[0].at_edge + STAGES - 1);
    check_output("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
    if (out_valid && ordy && sb.size() > 0) begin
      e = sb.pop_front();
      check_output("out_data", out_data, e.data);
      check_output("out_tag", {28'b0, out_tag}, {28'b0, e.tag});
    end
    accepted = iv && in_ready && !fl;
    @(posedge g_clk);
    edges++;
    if (fl) sb.delete();
    if (accepted) sb.push_back('{data: model(data, dec), tag: tag, at_edge: edges});
    #1;
  endtask

  task automatic drain(input int budget);
    int   n;
    logic a;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, a);
      n++;
    end
    check_output("drain_empty", 32'(sb.size()), 32'd0);
    repeat (2) apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, a);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        acc;
    logic [31:0] held;
    logic [31:0] bp_data [6];
    logic [31:0] d;
    int          idx;

    build_tables();
    $display("[TB] reset phase");
    repeat (3) @(posedge g_clk);
    #1;
    check_output("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_output("rst_out_data", out_data, 32'd0);
    check_output("rst_out_tag", {28'b0, out_tag}, 32'd0);
    g_rst = 1'b0;
    #1;
    check_output("rst_in_ready", {31'b0, in_ready}, 32'd1);

    $display("[TB] directed forward vector");
    apply_stimulus(1'b1, 32'h5301_00FF, 4'h5, 1'b0, 1'b0, 1'b0, acc);
    repeat (STAGES - 1) apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
    check_output("fwd_const_data", out_data, 32'hED7C_6316);
    check_output("fwd_const_tag", {28'b0, out_tag}, 32'd5);
    drain(10);

`ifdef AES_SBOX_INV_EN
    $display("[TB] directed inverse vector and alternating modes");
    apply_stimulus(1'b1, 32'hED7C_6316, 4'h6, 1'b1, 1'b0, 1'b0, acc);
    repeat (STAGES - 1) apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
    check_output("inv_const_data", out_data, 32'h5301_00FF);
    drain(10);
    for (int i = 0; i < 16; i++)
      apply_stimulus(1'b1, $urandom, 4'(i), i[0], 1'b1, 1'b0, acc);
    drain(10);
`endif

    $display("[TB] exhaustive byte sweep");
    for (int i = 0; i < 256; i++) begin
      d = {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)};
      apply_stimulus(1'b1, d, 4'(i), 1'b0, 1'b1, 1'b0, acc);
    end
    drain(10);
`ifdef AES_SBOX_INV_EN
    // Inverse fed with forward results: the expected values are the original sweep bytes.
    for (int i = 0; i < 256; i++) begin
      d = {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)};
      apply_stimulus(1'b1, model(d, 1'b0), 4'(i), 1'b1, 1'b1, 1'b0, acc);
    end
    drain(10);
`endif

    $display("[TB] backpressure");
    for (int i = 0; i < 6; i++) bp_data[i] = $urandom;
    idx  = 0;
    held = '0;
    for (int c = 0; c < 40 && (idx < 5 || sb.size() > 0); c++) begin
      if (c == 4) held = out_data;
      if (c == 5) check_output("bp_accepted", 32'(idx), 32'd3);
      if (c == 7) check_output("bp_stable", out_data, held);
      apply_stimulus(idx < 5, bp_data[idx], 4'(idx), 1'b0, c >= 8, 1'b0, acc);
      if (acc) idx++;
    end
    check_output("bp_all_sent", 32'(idx), 32'd5);
    drain(10);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++)
      apply_stimulus(1'($urandom), $urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'b0, acc);
    drain(20);

    $display("[TB] mid-stream flush");
    repeat (2) apply_stimulus(1'b1, $urandom, 4'h3, 1'b0, 1'b0, 1'b0, acc);
    apply_stimulus(1'b1, $urandom, 4'hF, 1'b0, 1'b0, 1'b1, acc);
    repeat (2) apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    apply_stimulus(1'b1, 32'h0000_0000, 4'h9, 1'b0, 1'b0, 1'b0, acc);
    repeat (STAGES - 1) apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
    check_output("flush_zero_data", out_data, 32'h6363_6363);
    check_output("flush_zero_tag", {28'b0, out_tag}, 32'd9);
    drain(10);

    $display("[TB] mid-stream reset");
    repeat (2) apply_stimulus(1'b1, $urandom, 4'h7, 1'b0, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    g_rst    = 1'b1;
    #1;
    check_output("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check_output("arst_out_data", out_data, 32'd0);
    check_output("arst_in_ready", {31'b0, in_ready}, 32'd1);
    sb.delete();
    @(posedge g_clk);
    #1;
    g_rst = 1'b0;
    repeat (3) apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
    apply_stimulus(1'b1, 32'h0000_0000, 4'hA, 1'b0, 1'b0, 1'b0, acc);
    repeat (STAGES - 1) apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
    check_output("arst_zero_data", out_data, 32'h6363_6363);
    drain(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
